// File: rtl/piano_pkg.sv
// ----------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the eight-voice square-wave piano mixer:
//   NUM_VOICES  - number of voices / keys
//   HALF_W      - width of a voice half-period counter
//   HALF_TABLE  - half-period (in samples) per voice, C4..C5, index = key bit
//   state_t     - mixer sequencing FSM states
// ----------------------------------------------------------------------------
package piano_pkg;

    localparam int NUM_VOICES = 8;
    localparam int HALF_W     = 7;
    localparam int IDX_W      = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

    // Entry 0 is C4 (92 samples), entry 7 is C5 (46 samples).
    localparam logic [NUM_VOICES-1:0][HALF_W-1:0] HALF_TABLE = {
        7'd46, 7'd49, 7'd55, 7'd61, 7'd69, 7'd73, 7'd82, 7'd92
    };

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WRITE    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

endpackage

// File: rtl/piano_square_voice.sv
// ----------------------------------------------------------------------------
// piano_square_voice
// One square-wave voice. The phase bit toggles every HALF advances while the
// key is held; releasing the key returns the voice to its start (cnt=0, ph=0)
// on the next advance.
// Ports:
//   CLOCK_50 - system clock
//   reset    - synchronous, active-high
//   pressed  - key state latched for the current sample
//   advance  - one-cycle pulse, step the voice by one sample
//   ph       - current phase (0 = positive half, 1 = negative half)
//   active   - voice contributes to the mix this sample
// ----------------------------------------------------------------------------
module piano_square_voice
    import piano_pkg::*;
#(
    parameter logic [HALF_W-1:0] HALF = 7'd92
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic pressed,
    input  logic advance,
    output logic ph,
    output logic active
);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else if (advance) begin
            if (!pressed) begin
                cnt <= '0;
                ph  <= 1'b0;
            end else if (cnt == HALF - 7'd1) begin
                cnt <= '0;
                ph  <= ~ph;
            end else begin
                cnt <= cnt + 7'd1;
            end
        end
    end

    assign active = pressed;

endmodule

// File: rtl/piano_tone_mixer.sv
// ----------------------------------------------------------------------------
// piano_tone_mixer
// Eight-voice square-wave synthesizer feeding the audio controller FIFO.
// One mono sample is produced each time audio_out_allowed is seen in IDLE;
// the voices are summed serially over eight ACCUM cycles, written in WRITE,
// and the FSM then waits two COOLDOWN cycles so the controller's registered
// audio_out_allowed reflects the write.
// Optional build macro: PIANO_KEY_SYNC_EN - pass keys through a 2-flop
// synchronizer (reset to the not-pressed level). Undefined: keys used as-is.
// Ports:
//   CLOCK_50                - system clock, 50 MHz
//   reset                   - synchronous, active-high
//   keys[7:0]               - key inputs, bit i selects note i
//   audio_out_allowed       - controller has FIFO space on both channels
//   left_channel_audio_out  - mixed sample, signed, held between writes
//   right_channel_audio_out - identical to left
//   write_audio_out         - one-cycle write strobe
// ----------------------------------------------------------------------------
module piano_tone_mixer
    import piano_pkg::*;
#(
    parameter logic signed [31:0] AMPLITUDE      = 32'sd10_000_000,
    parameter bit                 KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [NUM_VOICES-1:0] keys,
    input  logic                  audio_out_allowed,
    output logic [31:0]           left_channel_audio_out,
    output logic [31:0]           right_channel_audio_out,
    output logic                  write_audio_out
);

    function automatic logic signed [31:0] voice_value(input logic act, input logic p);
        if (!act)
            return 32'sd0;
        else if (p)
            return -AMPLITUDE;
        else
            return AMPLITUDE;
    endfunction

    logic [NUM_VOICES-1:0] keys_in;

`ifdef PIANO_KEY_SYNC_EN
    localparam logic [NUM_VOICES-1:0] KEY_IDLE = KEY_ACTIVE_LOW ? '1 : '0;
    logic [NUM_VOICES-1:0] keys_s1;
    logic [NUM_VOICES-1:0] keys_s2;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            keys_s1 <= KEY_IDLE;
            keys_s2 <= KEY_IDLE;
        end else begin
            keys_s1 <= keys;
            keys_s2 <= keys_s1;
        end
    end

    assign keys_in = keys_s2;
`else
    assign keys_in = keys;
`endif

    logic [NUM_VOICES-1:0] pressed_now;
    assign pressed_now = KEY_ACTIVE_LOW ? ~keys_in : keys_in;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx;
    logic                  cool_cnt;
    logic [NUM_VOICES-1:0] pressed_lat;
    logic signed [31:0]    acc;
    logic signed [31:0]    acc_sum;
    logic [NUM_VOICES-1:0] voice_ph;
    logic [NUM_VOICES-1:0] voice_active;
    logic                  advance;

    assign advance = (state == WRITE);

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        piano_square_voice #(
            .HALF (HALF_TABLE[g])
        ) u_voice (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .pressed  (pressed_lat[g]),
            .advance  (advance),
            .ph       (voice_ph[g]),
            .active   (voice_active[g])
        );
    end

    assign acc_sum = acc + voice_value(voice_active[idx], voice_ph[idx]);

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; audio_out_allowed only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (audio_out_allowed) state_nxt = ACCUM;
            ACCUM:    if (idx == LAST_IDX)   state_nxt = WRITE;
            WRITE:                           state_nxt = COOLDOWN;
            COOLDOWN: if (cool_cnt)          state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        write_audio_out = 1'b0;
        if (state == WRITE)
            write_audio_out = 1'b1;
    end

    // Datapath. The channel registers are loaded with the final sum on the
    // last ACCUM edge so the data is already valid during the WRITE strobe.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc                     <= '0;
            idx                     <= '0;
            cool_cnt                <= 1'b0;
            pressed_lat             <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cool_cnt <= 1'b0;
                    if (audio_out_allowed) begin
                        acc         <= '0;
                        idx         <= '0;
                        pressed_lat <= pressed_now;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    idx <= idx + 3'd1;
                    if (idx == LAST_IDX) begin
                        left_channel_audio_out  <= acc_sum;
                        right_channel_audio_out <= acc_sum;
                    end
                end
                WRITE: begin
                    cool_cnt <= 1'b0;
                end
                COOLDOWN: begin
                    cool_cnt <= ~cool_cnt;
                end
                default: begin
                    cool_cnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_tone_mixer.sv
// ----------------------------------------------------------------------------
// tb_piano_tone_mixer
// Directed self-checking bench for piano_tone_mixer (default build, keys
// active-low, AMPLITUDE = 10_000_000).
// ----------------------------------------------------------------------------
module tb_piano_tone_mixer;

    localparam logic signed [31:0] A = 32'sd10_000_000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [7:0]  keys;
    logic        audio_out_allowed;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        write_audio_out;

    int checks   = 0;
    int failures = 0;

    int half_p [8] = '{92, 82, 73, 69, 61, 55, 49, 46};

    piano_tone_mixer dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .keys                    (keys),
        .audio_out_allowed       (audio_out_allowed),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .write_audio_out         (write_audio_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Expected sample k after the voices in pr all started together from rest.
    function automatic logic signed [31:0] model(input logic [7:0] pr, input int k);
        logic signed [31:0] s;
        s = 0;
        for (int v = 0; v < 8; v++)
            if (pr[v])
                s = s + ((((k / half_p[v]) % 2) == 1) ? -A : A);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Wait (bounded) for the next strobe; n = negedges waited, -1 on timeout.
    task automatic next_write(output int n, output logic [31:0] l, output logic [31:0] r);
        n = -1;
        l = '0;
        r = '0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) begin
                n = i;
                l = left_channel_audio_out;
                r = right_channel_audio_out;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            failures++;
            $display("FAIL write_timeout observed=no_strobe expected=strobe");
        end
    endtask

    // Wait for a sample, check both channels and, if exp_n > 0, the spacing.
    task automatic sample(input string tag, input logic signed [31:0] exp, input int exp_n);
        int          n;
        logic [31:0] l, r;
        next_write(n, l, r);
        if (n > 0) begin
            chk({tag, "_left"}, l, exp);
            chk({tag, "_right"}, r, exp);
            if (exp_n > 0)
                chk({tag, "_spacing"}, n, exp_n);
        end
    endtask

    initial begin
        int          n;
        int          strobes;
        logic [31:0] l, r;
        logic [31:0] held;

        // ---------------- reset state
        reset             = 1'b1;
        keys              = 8'hFF;
        audio_out_allowed = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_write", {31'd0, write_audio_out}, 32'd0);
        chk("rst_left", left_channel_audio_out, 32'd0);
        chk("rst_right", right_channel_audio_out, 32'd0);

        // ---------------- silence, allowed held high: 9-cycle first latency, 12 spacing
        reset             = 1'b0;
        audio_out_allowed = 1'b1;
        sample("silent0", 32'sd0, 9);
        @(negedge CLOCK_50);
        chk("no_back_to_back", {31'd0, write_audio_out}, 32'd0);
        sample("silent1", 32'sd0, 11);
        sample("silent2", 32'sd0, 12);
        sample("silent3", 32'sd0, 12);

        // ---------------- key 0 (C4): 92 x +A, 92 x -A, period 184
        keys = 8'hFE;
        for (int k = 0; k < 186; k++)
            sample($sformatf("c4_k%0d", k), model(8'h01, k), 12);
        chk("c4_k91_const", model(8'h01, 91), A);

        // ---------------- keys 0 and 5 from rest
        keys = 8'hFF;
        sample("clear_05", 32'sd0, 12);
        keys = 8'hDE;
        for (int k = 0; k < 93; k++) begin
            next_write(n, l, r);
            if (k == 0)  chk("k05_first", l, 32'sd20_000_000);
            if (k == 55) chk("k05_s55", l, 32'sd0);
            if (k == 92) chk("k05_s92", l, -32'sd20_000_000);
            chk($sformatf("k05_k%0d", k), r, model(8'h21, k));
        end

        // ---------------- allowed low for 1000 cycles
        audio_out_allowed = 1'b0;
        held    = left_channel_audio_out;
        strobes = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) strobes++;
        end
        chk("stall_strobes", strobes, 0);
        chk("stall_left_held", left_channel_audio_out, held);
        chk("stall_right_held", right_channel_audio_out, held);
        audio_out_allowed = 1'b1;
        sample("resume", model(8'h21, 93), 9);

        // ---------------- reset in 4th ACCUM cycle with key 0 held
        keys = 8'hFE;
        repeat (7) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("mid_rst_write", {31'd0, write_audio_out}, 32'd0);
        chk("mid_rst_left", left_channel_audio_out, 32'd0);
        chk("mid_rst_right", right_channel_audio_out, 32'd0);
        reset = 1'b0;
        sample("post_rst_k0", A, 9);
        for (int k = 1; k < 93; k++)
            sample($sformatf("post_rst_k%0d", k), model(8'h01, k), 12);

        // ---------------- key 7 released while in its negative half, then re-pressed
        keys = 8'hFF;
        sample("clear_7", 32'sd0, 12);
        keys = 8'h7F;
        for (int k = 0; k <= 50; k++)
            sample($sformatf("c5_k%0d", k), model(8'h80, k), 12);
        keys = 8'hFF;
        sample("c5_released", 32'sd0, 12);
        keys = 8'h7F;
        for (int k = 0; k <= 46; k++)
            sample($sformatf("c5_re_k%0d", k), model(8'h80, k), 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piano_tone_mixer.md
# piano_tone_mixer

Eight-voice square-wave synthesizer that turns piano key presses into mono PCM samples for the audio controller's output FIFO. Sits directly upstream of the audio controller. It drives `left_channel_audio_out`, `right_channel_audio_out` and `write_audio_out`, and it paces itself on `audio_out_allowed`. The codec's 48 kHz frame rate therefore sets the sample rate, and no internal sample-rate divider exists.

## Interface
- `AMPLITUDE`, default 32'd10_000_000: per-voice peak magnitude. Must satisfy 8 × AMPLITUDE < 2^31.
- `KEY_ACTIVE_LOW`, default 1: when set, a key reads as pressed when its input is 0.
- `CLOCK_50` in, 1 bit: system clock, 50 MHz.
- `reset` in, 1 bit: synchronous, active-high; clock CLOCK_50.
- `keys` in, 8 bits: key inputs; bit i selects note i.
- `audio_out_allowed` in, 1 bit: the audio controller has FIFO space on both channels.
- `left_channel_audio_out` out, 32 bits: mixed sample, signed two's complement.
- `right_channel_audio_out` out, 32 bits: identical to the left channel.
- `write_audio_out` out, 1 bit: one-cycle write strobe into the controller.

## Operation
- Voice i holds a counter `cnt[i]` (7 bits) and a phase bit `ph[i]`. Half-periods in samples, notes C4 to C5:
  - 92 (C4), 82 (D4), 73 (E4), 69 (F4), 61 (G4), 55 (A4), 49 (B4), 46 (C5).
- The voice advance step runs only in the WRITE cycle:
  - Key pressed and `cnt == HALF-1`: set `cnt` to 0 and toggle `ph`.
  - Key pressed otherwise: `cnt` increments by 1.
  - Key not pressed: `cnt` = 0 and `ph` = 0.
- Voice contribution: +AMPLITUDE when `ph` = 0, −AMPLITUDE when `ph` = 1, 0 when the key is not pressed.
- FSM states:
  - **IDLE**: wait for `audio_out_allowed` = 1; on it, clear the accumulator, latch the pressed vector, set `idx` = 0, go to ACCUM.
  - **ACCUM**: add voice `idx`'s contribution to the 32-bit signed accumulator; `idx`++. After `idx` = 7, go to WRITE.
  - **WRITE**: drive both channel outputs from the accumulator, assert `write_audio_out` for exactly one cycle, advance all voices, go to COOLDOWN.
  - **COOLDOWN**: 2 cycles, so the controller's registered `audio_out_allowed` reflects the write before it is sampled again. Then go to IDLE.
- Channel outputs hold their last written value between writes.
- The pressed vector is latched once per sample. Key changes during ACCUM take effect at the next sample.
- `audio_out_allowed` is ignored outside IDLE. A deassertion during ACCUM does not abort the sample.
- No overflow handling is needed, because of the AMPLITUDE constraint.

## Timing
- Reset values:
  - FSM = IDLE.
  - `write_audio_out` = 0.
  - Both channel outputs = 0.
  - All `cnt` = 0, all `ph` = 0, accumulator = 0.
- A reset asserted in any state, including mid-ACCUM or in WRITE, takes effect at the next edge. The partial sample is discarded and no write is issued.
- Cycle schedule, with `audio_out_allowed` seen high in IDLE at cycle t:
  - ACCUM: t+1 to t+8.
  - WRITE (strobe high, data valid in the same cycle): t+9.
  - COOLDOWN: t+10 and t+11.
  - IDLE: t+12.
- Minimum spacing between writes is 12 cycles. The strobe is never high in consecutive cycles.
- Key-to-audio latency:
  - With `PIANO_KEY_SYNC_EN`: 2 cycles of synchronizer plus up to one sample period.
  - Without it: up to one sample period.

## Configuration
- `PIANO_KEY_SYNC_EN` defined: `keys` pass through a 2-flop synchronizer on CLOCK_50, reset to the not-pressed level.
- Undefined: `keys` are used directly. Only for benches and inputs that are already synchronous.

## Structure
- Package `piano_pkg`:
  - `NUM_VOICES` = 8.
  - Half-period table (8 × 7 bits).
  - FSM state enum (IDLE, ACCUM, WRITE, COOLDOWN).
- Sub-module `piano_square_voice`, instantiated 8 times:
  - Inputs: `HALF` parameter, `pressed`, `advance`.
  - Outputs: `ph`, `active`.
  - The top level holds the FSM, the accumulator and the output registers.

## Test plan
- No key pressed, `audio_out_allowed` held high → writes exactly every 12 cycles, every sample 0.
- Key 0 only (C4), allowed high:
  - First 92 samples = +10_000_000.
  - Next 92 samples = −10_000_000.
  - Repeats with period 184 samples.
- Keys 0 and 5 pressed → first sample +20_000_000. Sample 55 = 0 (A4 flipped, C4 not). Sample 92 = −20_000_000.
- `audio_out_allowed` = 0 for 1000 cycles → no write strobe, outputs unchanged. Allowed rises → strobe 9 cycles later.
- Reset pulsed at cycle t+4 of ACCUM with key 0 held → no strobe, outputs 0. The next sample restarts C4 at `cnt` = 0, `ph` = 0.
- Key 7 released mid-tone → its next advance clears `cnt` and `ph`. A re-press starts at +AMPLITUDE for 46 samples.
